// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the data-memory responder.
package mips_mem_pkg;

  // Responder FSM: waiting for a request, counting down latency, presenting a response
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Default byte addresses of the two memory-mapped observation registers
  localparam logic [31:0] DEFAULT_OUT1_ADDR = 32'h0000_1000;
  localparam logic [31:0] DEFAULT_OUT2_ADDR = 32'h0000_1004;

  // Width of the latency down-counter; supports LATENCY up to 15
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the MEM stage (master) and the responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word array with a registered read port.
// Read data only changes on an enabled load, so it stays stable while a
// response is waiting to be consumed. Contents are never reset.
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = 8
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // One access per enable: a store writes the word, a load registers it
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time with programmable latency,
// backed by a word array plus two memory-mapped observation registers.
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] OUT1_ADDR   = DEFAULT_OUT1_ADDR,
  parameter logic [31:0] OUT2_ADDR   = DEFAULT_OUT2_ADDR
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  dmem_responder_if.slave        bus,
  output logic [31:0]            out1_o,
  output logic [31:0]            out2_o
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [1:0][31:0] OUT_ADDRS = {OUT2_ADDR, OUT1_ADDR};

  // Illegal configurations stop elaboration
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be within 1..15");
  end
  if ({2'b00, OUT1_ADDR[31:2]} < DEPTH_WORDS) begin : g_bad_out1
    $error("dmem_responder: OUT1_ADDR overlaps the data array");
  end
  if ({2'b00, OUT2_ADDR[31:2]} < DEPTH_WORDS) begin : g_bad_out2
    $error("dmem_responder: OUT2_ADDR overlaps the data array");
  end

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic             rsp_sel_arr_q;
  logic [31:0]      rsp_data_q;
  logic [1:0][31:0] out_q;

  logic             access_fire;
  logic             dec_misaligned;
  logic             dec_array;
  logic [1:0]       dec_out;
  logic             rsp_err_d;
  logic             rsp_sel_arr_d;
  logic [31:0]      rsp_data_d;
  logic             arr_en;
  logic             arr_we;
  logic [1:0]       out_we;
  logic [31:0]      arr_rdata;

  assign access_fire    = (state_q == BUSY) && (cnt_q == '0);
  assign dec_misaligned = (addr_q[1:0] != 2'b00);
  assign dec_array      = ({2'b00, addr_q[31:2]} < DEPTH_WORDS);

  // Observation registers: address match and storage, one slice per register
  for (genvar gi = 0; gi < 2; gi++) begin : g_out
    logic [31:0] reg_q;

    assign dec_out[gi] = (addr_q == OUT_ADDRS[gi]);
    assign out_q[gi]   = reg_q;

    // Updated only on the access edge of a store to this register's address
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        reg_q <= '0;
      end else if (out_we[gi]) begin
        reg_q <= wdata_q;
      end
    end
  end

  assign out1_o = out_q[0];
  assign out2_o = out_q[1];

  // Priority address decode on the captured request: alignment, MMIO, array, else error
  always_comb begin
    rsp_err_d     = 1'b0;
    rsp_sel_arr_d = 1'b0;
    rsp_data_d    = '0;
    arr_en        = 1'b0;
    out_we        = '0;
    if (dec_misaligned) begin
      rsp_err_d = 1'b1;
    end else if (|dec_out) begin
      if (we_q) begin
        out_we = dec_out & {2{access_fire}};
      end else begin
        rsp_data_d = dec_out[0] ? out_q[0] : out_q[1];
      end
    end else if (dec_array) begin
      arr_en        = access_fire;
      rsp_sel_arr_d = ~we_q;
    end else begin
      rsp_err_d = 1'b1;
    end
  end

  assign arr_we = arr_en & we_q;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk_i   (clk_i),
    .en_i    (arr_en),
    .we_i    (arr_we),
    .addr_i  (addr_q[AW+1:2]),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );

  // Responder FSM: accept, count down the latency, perform the access, hold the response
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_sel_arr_q <= 1'b0;
      rsp_data_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            cnt_q   <= CNT_W'(LATENCY - 1);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= rsp_err_d;
            rsp_sel_arr_q <= rsp_sel_arr_d;
            rsp_data_q    <= rsp_data_d;
            state_q       <= RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  // Array loads take their data from the array's own read register
  assign bus.rsp_rdata = rsp_sel_arr_q ? arr_rdata : rsp_data_q;

endmodule
